cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the I-cache (read-only) and the D-cache (read/write) of the pipelined LC-3b.
- Data-side misses get priority, because a D-cache miss raises memstall and freezes the older instruction.
- A streak counter stops instruction fetch from starving.
- Sits between both cache controllers and the physical memory model; one transaction is outstanding at a time.

Parameters:
- MAX_D_STREAK, 4: consecutive D grants allowed while an I request waits. Legal range is 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- icache_read  in  1  I-cache line read request, held until icache_resp
- icache_address  in  16 (lc3b_word)  I-cache line address
- icache_resp  out  1  one-cycle completion pulse to the I-cache
- icache_rdata  out  128 (lc3b_line)  line data returned to the I-cache
- dcache_read  in  1  D-cache line read request, held until dcache_resp
- dcache_write  in  1  D-cache line writeback request, held until dcache_resp
- dcache_address  in  16  D-cache line address
- dcache_wdata  in  128  writeback line data
- dcache_resp  out  1  one-cycle completion pulse to the D-cache
- dcache_rdata  out  128  line data returned to the D-cache
- pmem_read  out  1  physical-memory read strobe
- pmem_write  out  1  physical-memory write strobe
- pmem_address  out  16  registered transaction address
- pmem_wdata  out  128  registered write data
- pmem_resp  in  1  physical memory done, one-cycle pulse
- pmem_rdata  in  128  physical memory read data
- arb_busy  out  1  high while a transaction is in flight

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, d_streak=0, addr/wdata/op registers=0. All outputs 0 (resp, strobes, address, wdata, arb_busy).
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE, choosing the next owner:
  - D pending (dcache_read|dcache_write) and no I pending: go to SERVE_D.
  - I pending and no D pending: go to SERVE_I.
  - Both pending: SERVE_I if d_streak==MAX_D_STREAK, otherwise SERVE_D.
  - Neither pending: stay in IDLE.
- At the grant edge, latch address, wdata and op (write when dcache_write=1, else read). dcache_write dominates if dcache_read and dcache_write are both high.
- d_streak update at each grant:
  - D granted while I pending: increment, saturating at MAX_D_STREAK.
  - I granted: clear to 0.
  - D granted with no I pending: clear to 0.
- SERVE_I / SERVE_D:
  - arb_busy=1; pmem_read or pmem_write driven from the latched op; pmem_address and pmem_wdata driven from the latched registers.
  - Strobes stay steady until pmem_resp.
- Response cycle (pmem_resp=1 in SERVE_x):
  - The owner's resp is driven combinationally equal to pmem_resp that cycle.
  - The owner's rdata equals pmem_rdata; the other rdata output is 0.
  - Next state is IDLE.
- Latency: request in IDLE at cycle 0 gives a strobe at cycle 1. pmem_resp at cycle k gives resp at cycle k. IDLE at cycle k+1, and the next strobe is at cycle k+2 (one bubble).
- pmem_resp while in IDLE is ignored; no resp is issued.
- A requester that drops its request mid-transaction does not abort it. The transaction completes and resp is still pulsed.
- Requests arriving during SERVE_x wait; only IDLE arbitrates.
- Reset mid-transaction: return to IDLE immediately and drop strobes. The in-flight transaction is abandoned with no resp.

Decomposition:
- lc3b_types holds:
  - lc3b_word (16b) and lc3b_line (128b);
  - the enum arb_state_t {IDLE, SERVE_I, SERVE_D};
  - the constant LINE_BITS=128.
- One sub-module, arb_streak_counter: a saturating counter with inc/clear/sat outputs, parameterised by MAX_D_STREAK.

Test Plan:
- I-only read: icache_read=1, addr 0x1230 → pmem_read=1 at cycle 1, pmem_address=0x1230. With pmem_resp at cycle 4, rdata=0xA5..A5: icache_resp=1 and icache_rdata=0xA5..A5 at cycle 4, dcache_resp=0.
- D writeback: dcache_write=1, addr 0x4000, wdata=0xDEADBEEF.. → pmem_write=1 and pmem_wdata matches from cycle 1. After resp, dcache_resp pulses once and arb_busy=0 at the next cycle.
- Simultaneous I/D: both requests at cycle 0 → D is served first; I is granted in the IDLE cycle following D's response.
- Starvation guard: I held high, D re-requesting back-to-back, MAX_D_STREAK=4 → exactly 4 D grants, then an I grant, then d_streak=0.
- Read+write both asserted by D: pmem_write=1 and pmem_read=0.
- Reset mid-SERVE_D: assert rst while waiting for pmem_resp → all outputs 0 immediately, no dcache_resp. After release, a fresh request is served normally.
- Stray response: pmem_resp pulsed in IDLE → no icache_resp or dcache_resp.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types for the LC-3b memory hierarchy.
//   lc3b_word   : 16-bit address/data word
//   lc3b_line   : one 128-bit cache line
//   arb_state_t : cache_arbiter FSM states
package lc3b_types;

    localparam int LINE_BITS = 128;

    typedef logic [15:0]          lc3b_word;
    typedef logic [LINE_BITS-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and physical memory.
//   slave  : arbiter side (takes cache requests and memory responses,
//            drives cache responses, memory strobes and arb_busy)
//   master : environment side (caches plus memory model)
interface cache_arbiter_if;
    import lc3b_types::*;

    logic     icache_read;
    lc3b_word icache_address;
    logic     icache_resp;
    lc3b_line icache_rdata;

    logic     dcache_read;
    logic     dcache_write;
    lc3b_word dcache_address;
    lc3b_line dcache_wdata;
    logic     dcache_resp;
    lc3b_line dcache_rdata;

    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    logic     pmem_resp;
    lc3b_line pmem_rdata;

    logic     arb_busy;

    modport slave (
        input  icache_read, icache_address,
        output icache_resp, icache_rdata,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        output dcache_resp, dcache_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata,
        output arb_busy
    );

    modport master (
        output icache_read, icache_address,
        input  icache_resp, icache_rdata,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  dcache_resp, dcache_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata,
        input  arb_busy
    );

endinterface

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive D-cache grants made while an I-cache
// request was waiting.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : add one (held at MAX_D_STREAK once reached)
//   clr      : return to zero (wins over inc)
//   count    : current streak
//   sat      : count has reached MAX_D_STREAK
module arb_streak_counter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count,
    output logic       sat
);

    assign sat = (count == 4'(MAX_D_STREAK));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache.
// D misses win because they stall the pipeline; a streak counter hands the
// port to a waiting I request after MAX_D_STREAK consecutive D grants.
// One transaction is outstanding at a time; only IDLE arbitrates.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cache_arbiter_if.slave (cache request/response, pmem port, arb_busy)
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  bus
);

    arb_state_t state;
    logic       op_write;
    lc3b_word   addr_q;
    lc3b_line   wdata_q;

    logic       i_pend;
    logic       d_pend;
    logic       grant_i;
    logic       grant_d;
    logic       streak_inc;
    logic       streak_clr;
    logic       streak_sat;
    logic [3:0] d_streak;

    assign i_pend = bus.icache_read;
    assign d_pend = bus.dcache_read | bus.dcache_write;

    // D wins unless an I request has already waited through a full streak.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (d_pend && !(i_pend && streak_sat)) begin
                grant_d = 1'b1;
            end else if (i_pend) begin
                grant_i = 1'b1;
            end
        end
    end

    assign streak_inc = grant_d & i_pend;
    assign streak_clr = grant_i | (grant_d & ~i_pend);

    arb_streak_counter #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .inc   (streak_inc),
        .clr   (streak_clr),
        .count (d_streak),
        .sat   (streak_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= SERVE_D;
                        addr_q   <= bus.dcache_address;
                        wdata_q  <= bus.dcache_wdata;
                        op_write <= bus.dcache_write;
                    end else if (grant_i) begin
                        state    <= SERVE_I;
                        addr_q   <= bus.icache_address;
                        wdata_q  <= '0;
                        op_write <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.pmem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.arb_busy     = (state != IDLE);
    assign bus.pmem_read    = bus.arb_busy & ~op_write;
    assign bus.pmem_write   = bus.arb_busy & op_write;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;

    // A response seen in IDLE belongs to nobody and is dropped here.
    assign bus.icache_resp  = (state == SERVE_I) & bus.pmem_resp;
    assign bus.dcache_resp  = (state == SERVE_D) & bus.pmem_resp;
    assign bus.icache_rdata = (state == SERVE_I) ? bus.pmem_rdata : '0;
    assign bus.dcache_rdata = (state == SERVE_D) ? bus.pmem_rdata : '0;

    logic unused_d_streak;
    assign unused_d_streak = ^d_streak;

endmodule
